multicycle_control: RTL and testbench

//  Multi-cycle sequencer for the RV32I core. It replaces single-cycle opcode decode with a

---
 rtl/rv_ctrl_pkg.sv | 69 ++++++
 rtl/multicycle_control.sv | 199 +++++++++++++++++++
 tb/tb_multicycle_control.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle sequencer: opcodes, FSM states,
// ALU op classes, PC source selects and trap causes.
package rv_ctrl_pkg;

  localparam logic [6:0] OPCODE_R     = 7'b0110011;
  localparam logic [6:0] OPCODE_I     = 7'b0010011;
  localparam logic [6:0] OPCODE_LOAD  = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE = 7'b0100011;
  localparam logic [6:0] OPCODE_B     = 7'b1100011;
  localparam logic [6:0] OPCODE_LUI   = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC = 7'b0010111;
  localparam logic [6:0] OPCODE_JAL   = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR  = 7'b1100111;

  typedef enum logic [3:0] {
    ST_FETCH      = 4'd0,
    ST_DECODE     = 4'd1,
    ST_EXEC_R     = 4'd2,
    ST_EXEC_I     = 4'd3,
    ST_EXEC_LUI   = 4'd4,
    ST_EXEC_AUIPC = 4'd5,
    ST_WB_ALU     = 4'd6,
    ST_MEM_ADDR   = 4'd7,
    ST_MEM_RD     = 4'd8,
    ST_WB_MEM     = 4'd9,
    ST_MEM_WR     = 4'd10,
    ST_BRANCH     = 4'd11,
    ST_JAL        = 4'd12,
    ST_JALR       = 4'd13,
    ST_TRAP       = 4'd14
  } state_t;

  localparam logic [2:0] ALU_OP_ADD   = 3'b000;
  localparam logic [2:0] ALU_OP_SUB   = 3'b001;
  localparam logic [2:0] ALU_OP_R     = 3'b010;
  localparam logic [2:0] ALU_OP_I     = 3'b011;
  localparam logic [2:0] ALU_OP_PASSB = 3'b100;

  localparam logic [1:0] PC_SRC_PC4    = 2'b00;
  localparam logic [1:0] PC_SRC_TARGET = 2'b01;
  localparam logic [1:0] PC_SRC_ALU    = 2'b10;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_IMEM    = 2'b10;
  localparam logic [1:0] CAUSE_DMEM    = 2'b11;

  typedef struct packed {
    logic [2:0] op;
    logic       src;
    logic       data1;
  } alu_ctrl_t;

  // WB_ALU is shared by all ALU-class instructions, so it re-derives the
  // EXEC controls from the still-valid opcode to keep the result stable.
  function automatic alu_ctrl_t wb_alu_ctrl(input logic [6:0] opcode);
    alu_ctrl_t c;
    c = '{op: ALU_OP_ADD, src: 1'b0, data1: 1'b0};
    case (opcode)
      OPCODE_R:     c = '{op: ALU_OP_R,     src: 1'b0, data1: 1'b0};
      OPCODE_I:     c = '{op: ALU_OP_I,     src: 1'b1, data1: 1'b0};
      OPCODE_LUI:   c = '{op: ALU_OP_PASSB, src: 1'b1, data1: 1'b0};
      OPCODE_AUIPC: c = '{op: ALU_OP_ADD,   src: 1'b1, data1: 1'b1};
      default:      c = '{op: ALU_OP_ADD,   src: 1'b0, data1: 1'b0};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I sequencer: steps the shared datapath through fetch, decode,
// execute, memory and writeback, with memory wait timeouts and a sticky trap.
module multicycle_control
  import rv_ctrl_pkg::*;
#(
  parameter int WAIT_MAX = 15
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [6:0] opcode_i,
  input  logic       imem_ready_i,
  input  logic       dmem_ready_i,
  input  logic       branch_taken_i,
  output logic       imem_req_o,
  output logic       dmem_req_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       ir_write_o,
  output logic       pc_write_o,
  output logic [1:0] pc_src_o,
  output logic       reg_write_o,
  output logic       men_to_reg_o,
  output logic       link_o,
  output logic [2:0] alu_op_o,
  output logic       alu_src_o,
  output logic       alu_data1_o,
  output logic       retire_o,
  output logic       halted_o,
  output logic [1:0] cause_o,
  output logic [3:0] state_o
);

  // Handshake: a memory access completes in the first cycle where the request
  // is high and the matching ready is high; ready outside a request is ignored.

  localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

  state_t     state, state_next;
  logic [1:0] cause_q, cause_next;
  logic [7:0] wait_cnt;
  logic       waiting;
  logic       live;
  alu_ctrl_t  wb_ctrl;

  assign live    = ~rst_i;
  assign wb_ctrl = wb_alu_ctrl(opcode_i);
  assign state_o = state;
  assign cause_o = cause_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= ST_FETCH;
      cause_q  <= CAUSE_NONE;
      wait_cnt <= 8'd0;
    end else begin
      state   <= state_next;
      cause_q <= cause_next;
      if (state_next != state) wait_cnt <= 8'd0;
      else if (waiting)        wait_cnt <= wait_cnt + 8'd1;
    end
  end

  always_comb begin
    state_next = state;
    cause_next = cause_q;
    waiting    = 1'b0;
    case (state)
      ST_FETCH: begin
        if (imem_ready_i) state_next = ST_DECODE;
        else begin
          waiting = 1'b1;
          if (wait_cnt == WAIT_LAST) begin
            state_next = ST_TRAP;
            cause_next = CAUSE_IMEM;
          end
        end
      end
      ST_DECODE: begin
        case (opcode_i)
          OPCODE_R:     state_next = ST_EXEC_R;
          OPCODE_I:     state_next = ST_EXEC_I;
          OPCODE_LOAD,
          OPCODE_STORE: state_next = ST_MEM_ADDR;
          OPCODE_B:     state_next = ST_BRANCH;
          OPCODE_LUI:   state_next = ST_EXEC_LUI;
          OPCODE_AUIPC: state_next = ST_EXEC_AUIPC;
          OPCODE_JAL:   state_next = ST_JAL;
          OPCODE_JALR:  state_next = ST_JALR;
          default: begin
            state_next = ST_TRAP;
            cause_next = CAUSE_ILLEGAL;
          end
        endcase
      end
      ST_EXEC_R, ST_EXEC_I, ST_EXEC_LUI, ST_EXEC_AUIPC: state_next = ST_WB_ALU;
      ST_MEM_ADDR: state_next = (opcode_i == OPCODE_STORE) ? ST_MEM_WR : ST_MEM_RD;
      ST_MEM_RD, ST_MEM_WR: begin
        if (dmem_ready_i) state_next = (state == ST_MEM_RD) ? ST_WB_MEM : ST_FETCH;
        else begin
          waiting = 1'b1;
          if (wait_cnt == WAIT_LAST) begin
            state_next = ST_TRAP;
            cause_next = CAUSE_DMEM;
          end
        end
      end
      ST_WB_ALU, ST_WB_MEM, ST_BRANCH, ST_JAL, ST_JALR: state_next = ST_FETCH;
      ST_TRAP: state_next = ST_TRAP;
      default: state_next = ST_FETCH;
    endcase
  end

  always_comb begin
    imem_req_o   = 1'b0;
    dmem_req_o   = 1'b0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    ir_write_o   = 1'b0;
    pc_write_o   = 1'b0;
    pc_src_o     = PC_SRC_PC4;
    reg_write_o  = 1'b0;
    men_to_reg_o = 1'b0;
    link_o       = 1'b0;
    alu_op_o     = ALU_OP_ADD;
    alu_src_o    = 1'b0;
    alu_data1_o  = 1'b0;
    retire_o     = 1'b0;
    halted_o     = 1'b0;
    case (state)
      ST_FETCH: begin
        imem_req_o = 1'b1;
        ir_write_o = imem_ready_i & live;
        pc_write_o = imem_ready_i & live;
      end
      ST_EXEC_R: alu_op_o = ALU_OP_R;
      ST_EXEC_I: begin
        alu_op_o  = ALU_OP_I;
        alu_src_o = 1'b1;
      end
      ST_EXEC_LUI: begin
        alu_op_o  = ALU_OP_PASSB;
        alu_src_o = 1'b1;
      end
      ST_EXEC_AUIPC: begin
        alu_op_o    = ALU_OP_ADD;
        alu_src_o   = 1'b1;
        alu_data1_o = 1'b1;
      end
      ST_WB_ALU: begin
        alu_op_o    = wb_ctrl.op;
        alu_src_o   = wb_ctrl.src;
        alu_data1_o = wb_ctrl.data1;
        reg_write_o = 1'b1;
        retire_o    = 1'b1;
      end
      ST_MEM_ADDR: alu_src_o = 1'b1;
      ST_MEM_RD: begin
        dmem_req_o = 1'b1;
        mem_read_o = 1'b1;
        alu_src_o  = 1'b1;
      end
      ST_WB_MEM: begin
        reg_write_o  = 1'b1;
        men_to_reg_o = 1'b1;
        retire_o     = 1'b1;
      end
      ST_MEM_WR: begin
        dmem_req_o  = 1'b1;
        mem_write_o = 1'b1;
        alu_src_o   = 1'b1;
        retire_o    = dmem_ready_i & live;
      end
      ST_BRANCH: begin
        alu_op_o   = ALU_OP_SUB;
        pc_src_o   = PC_SRC_TARGET;
        pc_write_o = branch_taken_i;
        retire_o   = 1'b1;
      end
      ST_JAL: begin
        reg_write_o = 1'b1;
        link_o      = 1'b1;
        pc_src_o    = PC_SRC_TARGET;
        pc_write_o  = 1'b1;
        retire_o    = 1'b1;
      end
      ST_JALR: begin
        alu_src_o   = 1'b1;
        reg_write_o = 1'b1;
        link_o      = 1'b1;
        pc_src_o    = PC_SRC_ALU;
        pc_write_o  = 1'b1;
        retire_o    = 1'b1;
      end
      ST_TRAP: halted_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control with WAIT_MAX=4: per-instruction
// cycle counts and strobes, reset mid-access, illegal opcode and timeouts.
module tb_multicycle_control;
  import rv_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic       imem_ready, dmem_ready, branch_taken;
  logic       imem_req, dmem_req, mem_read, mem_write, ir_write, pc_write;
  logic [1:0] pc_src, cause;
  logic       reg_write, men_to_reg, link, alu_src, alu_data1, retire, halted;
  logic [2:0] alu_op;
  logic [3:0] state_dbg;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  multicycle_control #(.WAIT_MAX(4)) dut (
    .clk_i(clk), .rst_i(rst), .opcode_i(opcode),
    .imem_ready_i(imem_ready), .dmem_ready_i(dmem_ready), .branch_taken_i(branch_taken),
    .imem_req_o(imem_req), .dmem_req_o(dmem_req), .mem_read_o(mem_read),
    .mem_write_o(mem_write), .ir_write_o(ir_write), .pc_write_o(pc_write),
    .pc_src_o(pc_src), .reg_write_o(reg_write), .men_to_reg_o(men_to_reg),
    .link_o(link), .alu_op_o(alu_op), .alu_src_o(alu_src), .alu_data1_o(alu_data1),
    .retire_o(retire), .halted_o(halted), .cause_o(cause), .state_o(state_dbg)
  );

  // {imem_req,dmem_req,mem_read,mem_write,ir_write,pc_write,pc_src,reg_write,
  //  men_to_reg,link,alu_op,alu_src,alu_data1,retire,halted,cause}
  function automatic logic [19:0] outv();
    return {imem_req, dmem_req, mem_read, mem_write, ir_write, pc_write, pc_src,
            reg_write, men_to_reg, link, alu_op, alu_src, alu_data1, retire,
            halted, cause};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic run(input string tag, input logic [6:0] op, input logic taken,
                     input int di, input int dd, input int len,
                     input int e_regw, input int e_pcw, input int e_rd, input int e_wr,
                     input logic [1:0] e_pcsrc, input logic [2:0] e_alu);
    int ret_at, n_regw, n_pcw, n_rd, n_wr, n_irw;
    logic [1:0] pcsrc_r;
    logic [2:0] alu_r;
    ret_at = 0; n_regw = 0; n_pcw = 0; n_rd = 0; n_wr = 0; n_irw = 0;
    pcsrc_r = 2'b11; alu_r = 3'b111;
    for (int c = 1; c <= len; c++) begin
      opcode       = op;
      branch_taken = taken;
      imem_ready   = (c > di);
      dmem_ready   = (c >= di + 4 + dd);
      @(negedge clk);
      if (retire && ret_at == 0) begin
        ret_at  = c;
        pcsrc_r = pc_src;
        alu_r   = alu_op;
      end
      n_regw += int'(reg_write);
      n_pcw  += int'(pc_write);
      n_rd   += int'(mem_read);
      n_wr   += int'(mem_write);
      n_irw  += int'(ir_write);
      step();
    end
    check({tag, "_retire_cycle"}, 32'(ret_at), 32'(len));
    check({tag, "_reg_write_cnt"}, 32'(n_regw), 32'(e_regw));
    check({tag, "_pc_write_cnt"}, 32'(n_pcw), 32'(e_pcw));
    check({tag, "_mem_read_cnt"}, 32'(n_rd), 32'(e_rd));
    check({tag, "_mem_write_cnt"}, 32'(n_wr), 32'(e_wr));
    check({tag, "_ir_write_cnt"}, 32'(n_irw), 32'd1);
    check({tag, "_pc_src_at_retire"}, 32'(pcsrc_r), 32'(e_pcsrc));
    check({tag, "_alu_op_at_retire"}, 32'(alu_r), 32'(e_alu));
    check({tag, "_back_to_fetch"}, 32'(state_dbg), 32'(ST_FETCH));
  endtask

  initial begin
    rst = 1'b1; opcode = 7'd0; imem_ready = 1'b0; dmem_ready = 1'b0; branch_taken = 1'b0;
    #1;
    check("reset_outputs", 32'(outv()), 32'h80000);
    check("reset_state", 32'(state_dbg), 32'(ST_FETCH));
    step();
    rst = 1'b0;

    // R-type back to back with both readies high: retire every 4th cycle
    for (int c = 1; c <= 8; c++) begin
      opcode = OPCODE_R; imem_ready = 1'b1; dmem_ready = 1'b1;
      @(negedge clk);
      check("rr_retire", 32'(retire), 32'((c % 4) == 0));
      check("rr_reg_write", 32'(reg_write), 32'((c % 4) == 0));
      if (c % 4 == 3) check("rr_alu_op", 32'(alu_op), 32'(ALU_OP_R));
      step();
    end

    //   tag      op            tk  di dd len regw pcw rd wr pcsrc alu
    run("r",     OPCODE_R,     0, 0, 0, 4,  1, 1, 0, 0, 2'b00, 3'b010);
    run("i_w2",  OPCODE_I,     0, 2, 0, 6,  1, 1, 0, 0, 2'b00, 3'b011);
    run("lui",   OPCODE_LUI,   0, 0, 0, 4,  1, 1, 0, 0, 2'b00, 3'b100);
    run("auipc", OPCODE_AUIPC, 0, 0, 0, 4,  1, 1, 0, 0, 2'b00, 3'b000);
    run("load3", OPCODE_LOAD,  0, 0, 3, 8,  1, 1, 4, 0, 2'b00, 3'b000);
    run("store", OPCODE_STORE, 0, 0, 1, 5,  0, 1, 0, 2, 2'b00, 3'b000);
    run("beq_t", OPCODE_B,     1, 0, 0, 3,  0, 2, 0, 0, 2'b01, 3'b001);
    run("beq_n", OPCODE_B,     0, 0, 0, 3,  0, 1, 0, 0, 2'b01, 3'b001);
    run("jal",   OPCODE_JAL,   0, 0, 0, 3,  1, 2, 0, 0, 2'b01, 3'b000);
    run("jalr",  OPCODE_JALR,  0, 0, 0, 3,  1, 2, 0, 0, 2'b10, 3'b000);

    // Reset in the middle of a load's data access
    opcode = OPCODE_LOAD; imem_ready = 1'b1; dmem_ready = 1'b0;
    for (int c = 1; c <= 4; c++) step();
    check("midrd_mem_read", 32'(mem_read), 32'd1);
    rst = 1'b1;
    #1;
    check("midrd_reset_outputs", 32'(outv()), 32'h80000);
    check("midrd_reset_state", 32'(state_dbg), 32'(ST_FETCH));
    step();
    rst = 1'b0;
    run("load_after_rst", OPCODE_LOAD, 0, 0, 2, 7, 1, 1, 3, 0, 2'b00, 3'b000);

    // Illegal opcode traps and stays trapped
    opcode = 7'b1111111; imem_ready = 1'b1;
    step(); step();
    @(negedge clk);
    check("illegal_trap_outputs", 32'(outv()), 32'h00005);
    check("illegal_state", 32'(state_dbg), 32'(ST_TRAP));
    opcode = OPCODE_R; dmem_ready = 1'b1;
    for (int c = 0; c < 3; c++) step();
    @(negedge clk);
    check("illegal_sticky", 32'(outv()), 32'h00005);
    step();
    rst = 1'b1;
    #1;
    check("illegal_cleared", 32'(outv()), 32'h80000);
    step();
    rst = 1'b0;

    // Instruction fetch timeout: four wait cycles then trap
    imem_ready = 1'b0; dmem_ready = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 4) check("imem_to_not_yet", 32'(halted), 32'd0);
      step();
    end
    @(negedge clk);
    check("imem_timeout_outputs", 32'(outv()), 32'h00006);
    step();
    do_reset();

    // Ready arriving on the last allowed cycle wins
    for (int c = 1; c <= 4; c++) begin
      imem_ready = (c == 4);
      @(negedge clk);
      if (c == 4) check("imem_late_ir_write", 32'(ir_write), 32'd1);
      step();
    end
    imem_ready = 1'b0;
    @(negedge clk);
    check("imem_late_state", 32'(state_dbg), 32'(ST_DECODE));
    check("imem_late_halted", 32'(halted), 32'd0);
    step();
    do_reset();

    // Data read timeout
    opcode = OPCODE_LOAD; imem_ready = 1'b1; dmem_ready = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 7) check("dmem_to_not_yet", 32'({mem_read, halted}), 32'b10);
      step();
    end
    @(negedge clk);
    check("dmem_timeout_outputs", 32'(outv()), 32'h00007);
    step();
    do_reset();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    n_errors++;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
